// File: rtl/spike_output_queue.sv
// rtl/spike_output_queue.sv - membrane writeback and spiking-neuron ID FIFO after the threshold stage
module spike_output_queue #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int NEURON_ID_WIDTH = 11,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic                              InValid,
    output logic                              InReady,
    input  logic [NEURON_ID_WIDTH-1:0]        InNeuronID,
    input  logic                              SpikeIn,
    input  logic signed [DATA_WIDTH-1:0]      VmemIn,
    output logic                              VmemWrEn,
    output logic [NEURON_ID_WIDTH-1:0]        VmemWrAddr,
    output logic signed [DATA_WIDTH-1:0]      VmemWrData,
    output logic                              SpikeOutValid,
    input  logic                              SpikeOutReady,
    output logic [NEURON_ID_WIDTH-1:0]        SpikeOutID,
    output logic [FIFO_DEPTH_BITS:0]          FifoCount,
    input  logic                              ClearStats,
    output logic [31:0]                       SpikeCount
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE = 1;
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE = 1;

    logic [NEURON_ID_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic                       accept;
    logic                       push;
    logic                       pop;

    // Occupancy never exceeds DEPTH, so the count MSB alone marks "full".
    assign InReady       = ~FifoCount[FIFO_DEPTH_BITS];
    assign SpikeOutValid = (FifoCount != '0);
    assign SpikeOutID    = mem[rd_ptr];

    assign accept = InValid && InReady;
    assign push   = accept && SpikeIn;
    assign pop    = SpikeOutValid && SpikeOutReady;

    // ID storage carries no reset; stale entries are unreachable once the count clears.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= InNeuronID;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            FifoCount <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   FifoCount <= FifoCount + CNT_ONE;
                2'b01:   FifoCount <= FifoCount - CNT_ONE;
                default: FifoCount <= FifoCount;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            VmemWrEn   <= 1'b0;
            VmemWrAddr <= '0;
            VmemWrData <= '0;
        end else begin
            VmemWrEn <= accept;
            if (accept) begin
                VmemWrAddr <= InNeuronID;
                VmemWrData <= VmemIn;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            SpikeCount <= '0;
        end else if (ClearStats) begin
            SpikeCount <= '0;
        end else if (push && (SpikeCount != 32'hFFFF_FFFF)) begin
            SpikeCount <= SpikeCount + 32'd1;
        end
    end

endmodule
